// File: rtl/add_sub_align_swap_pipe.sv
// add_sub_align_swap_pipe: two-stage operand-ordering stage for the FPU add/sub path.
// S1 registers the operands, the magnitude compare and both exponent differences.
// S2 registers the swapped operands with the diff, saturation, swap, eff_sub and sign flags.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// o_ready is combinational from i_ready (no skid buffer), and a held o_valid keeps
// every output stable until i_ready accepts it.
// Optional macro ADD_SUB_SWAP_MANT_CMP_EN: compare {exp,man} instead of exp only.
module add_sub_align_swap_pipe #(
    parameter  int SIZE_EXP  = 8,
    parameter  int SIZE_MAN  = 23,
    localparam int SIZE_DATA = 1 + SIZE_EXP + SIZE_MAN
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    input  logic                 i_sub,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_greater_data,
    output logic [SIZE_DATA-1:0] o_less_data,
    output logic [SIZE_EXP-1:0]  o_exp_diff,
    output logic                 o_shift_sat,
    output logic                 o_swapped,
    output logic                 o_eff_sub,
    output logic                 o_sign_res
);

    // Alignment beyond mantissa + guard/round/sticky shifts everything out.
    localparam int                SAT_INT = SIZE_MAN + 3;
    localparam logic [SIZE_EXP:0] SAT_LIM = SAT_INT[SIZE_EXP:0];

    // Stage 1 registers
    logic                 r_s1_valid;
    logic [SIZE_DATA-1:0] r_s1_a;
    logic [SIZE_DATA-1:0] r_s1_b;
    logic                 r_s1_sub;
    logic                 r_s1_lt;
    logic [SIZE_EXP-1:0]  r_s1_diff_ab;
    logic [SIZE_EXP-1:0]  r_s1_diff_ba;

    // Stage 2 registers (drive the outputs directly)
    logic                 r_s2_valid;
    logic [SIZE_DATA-1:0] r_s2_greater;
    logic [SIZE_DATA-1:0] r_s2_less;
    logic [SIZE_EXP-1:0]  r_s2_diff;
    logic                 r_s2_sat;
    logic                 r_s2_swapped;
    logic                 r_s2_eff_sub;
    logic                 r_s2_sign_res;

    logic                 w_s2_adv;
    logic                 w_s1_adv;
    logic [SIZE_EXP-1:0]  w_exp_a;
    logic [SIZE_EXP-1:0]  w_exp_b;
    logic                 w_lt;
    logic [SIZE_EXP-1:0]  w_s2_diff;
    logic                 w_sign_a;
    logic                 w_sign_b;

    assign w_s2_adv = !r_s2_valid || i_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign o_ready  = w_s1_adv;

    assign w_exp_a = i_data_a[SIZE_DATA-2 -: SIZE_EXP];
    assign w_exp_b = i_data_b[SIZE_DATA-2 -: SIZE_EXP];

    // Sign bits never take part in the ordering; equal keys leave A as greater.
`ifdef ADD_SUB_SWAP_MANT_CMP_EN
    assign w_lt = i_data_a[SIZE_DATA-2:0] < i_data_b[SIZE_DATA-2:0];
`else
    assign w_lt = w_exp_a < w_exp_b;
`endif

    // The selected difference is always the non-negative one.
    assign w_s2_diff = r_s1_lt ? r_s1_diff_ba : r_s1_diff_ab;
    assign w_sign_a  = r_s1_a[SIZE_DATA-1];
    assign w_sign_b  = r_s1_b[SIZE_DATA-1];

    // Stage 1: capture operands, compare result and both exponent differences.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_sub     <= 1'b0;
            r_s1_lt      <= 1'b0;
            r_s1_diff_ab <= '0;
            r_s1_diff_ba <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_a       <= i_data_a;
                r_s1_b       <= i_data_b;
                r_s1_sub     <= i_sub;
                r_s1_lt      <= w_lt;
                r_s1_diff_ab <= w_exp_a - w_exp_b;
                r_s1_diff_ba <= w_exp_b - w_exp_a;
            end
        end
    end

    // Stage 2: apply the swap and register the derived flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid    <= 1'b0;
            r_s2_greater  <= '0;
            r_s2_less     <= '0;
            r_s2_diff     <= '0;
            r_s2_sat      <= 1'b0;
            r_s2_swapped  <= 1'b0;
            r_s2_eff_sub  <= 1'b0;
            r_s2_sign_res <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_greater  <= r_s1_lt ? r_s1_b : r_s1_a;
                r_s2_less     <= r_s1_lt ? r_s1_a : r_s1_b;
                r_s2_diff     <= w_s2_diff;
                r_s2_sat      <= {1'b0, w_s2_diff} >= SAT_LIM;
                r_s2_swapped  <= r_s1_lt;
                r_s2_eff_sub  <= w_sign_a ^ w_sign_b ^ r_s1_sub;
                r_s2_sign_res <= r_s1_lt ? (w_sign_b ^ r_s1_sub) : w_sign_a;
            end
        end
    end

    assign o_valid        = r_s2_valid;
    assign o_greater_data = r_s2_greater;
    assign o_less_data    = r_s2_less;
    assign o_exp_diff     = r_s2_diff;
    assign o_shift_sat    = r_s2_sat;
    assign o_swapped      = r_s2_swapped;
    assign o_eff_sub      = r_s2_eff_sub;
    assign o_sign_res     = r_s2_sign_res;

endmodule

// File: tb/tb_add_sub_align_swap_pipe.sv
// Bench for add_sub_align_swap_pipe (default 8/23 format).
// Expected bundles are pushed to exp_q when an input is accepted and popped by
// the negedge monitor whenever an output is consumed.
module tb_add_sub_align_swap_pipe;
  localparam int DW = 32;
  localparam int EW = 2 * DW + 8 + 4;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data_a = '0;
  logic [DW-1:0] i_data_b = '0;
  logic          i_sub = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b1;
  logic [DW-1:0] o_greater_data;
  logic [DW-1:0] o_less_data;
  logic [7:0]    o_exp_diff;
  logic          o_shift_sat;
  logic          o_swapped;
  logic          o_eff_sub;
  logic          o_sign_res;

  logic [EW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  add_sub_align_swap_pipe #(.SIZE_EXP(8), .SIZE_MAN(23)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data_a(i_data_a), .i_data_b(i_data_b), .i_sub(i_sub),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_greater_data(o_greater_data), .o_less_data(o_less_data),
    .o_exp_diff(o_exp_diff), .o_shift_sat(o_shift_sat), .o_swapped(o_swapped),
    .o_eff_sub(o_eff_sub), .o_sign_res(o_sign_res)
  );

  wire [EW-1:0] act_bundle = {o_greater_data, o_less_data, o_exp_diff,
                              o_shift_sat, o_swapped, o_eff_sub, o_sign_res};

  // Reference model: ordering, difference, saturation at 23+3 and sign rules.
  function automatic logic [EW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic sub);
    logic          a_less;
    logic [DW-1:0] g;
    logic [DW-1:0] l;
    int            d;
    logic          sr;
`ifdef ADD_SUB_SWAP_MANT_CMP_EN
    a_less = (a[30:0] < b[30:0]);
`else
    a_less = (a[30:23] < b[30:23]);
`endif
    g  = a_less ? b : a;
    l  = a_less ? a : b;
    d  = int'(g[30:23]) - int'(l[30:23]);
    sr = a_less ? (b[31] ^ sub) : a[31];
    return {g, l, 8'(d), (d >= 26), a_less, a[31] ^ b[31] ^ sub, sr};
  endfunction

  // Monitor: every consumed output must match the head of the queue.
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got %h, queue empty", act_bundle);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (act_bundle !== e) begin
          n_fail++;
          $display("FAIL output_bundle: got %h expected %h", act_bundle, e);
        end
      end
    end
  end

  // Present one transaction and hold it until accepted (bounded).
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
    int waited = 0;
    i_valid = 1'b1; i_data_a = a; i_data_b = b; i_sub = sub;
    @(negedge clk);
    while (!o_ready && waited < 40) begin
      @(posedge clk); #1;
      @(negedge clk);
      waited++;
    end
    if (!o_ready) begin
      n_tests++; n_fail++;
      $display("FAIL accept_timeout: o_ready=%b expected 1", o_ready);
    end else begin
      exp_q.push_back(model(a, b, sub));
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int waited = 0;
    i_valid = 1'b0;
    while (exp_q.size() != 0 && waited < 60) begin @(posedge clk); #1; waited++; end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d outputs still pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b1; i_data_a = 32'h40400000; i_data_b = 32'h3F800000;
    repeat (2) @(posedge clk);
    #1; i_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0 || act_bundle !== '0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: o_valid=%b bundle=%h o_ready=%b expected 0/0/1",
               o_valid, act_bundle, o_ready);
    end
    @(posedge clk); #1; i_rst = 1'b0;
  endtask

  task automatic test_ordering();
    i_ready = 1'b1;
    send(32'h40400000, 32'h3F800000, 1'b0);
    i_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early: o_valid=%b expected 0", o_valid);
    end
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1 || o_greater_data !== 32'h40400000 || o_less_data !== 32'h3F800000 ||
        o_exp_diff !== 8'd1 || o_swapped !== 1'b0 || o_shift_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL ordering: v=%b g=%h l=%h d=%0d sw=%b sat=%b expected 1/40400000/3f800000/1/0/0",
               o_valid, o_greater_data, o_less_data, o_exp_diff, o_swapped, o_shift_sat);
    end
    drain();
  endtask

  task automatic test_swap_sign();
    send(32'h3F800000, 32'h40400000, 1'b1);
    send(32'h3F800000, 32'hC0400000, 1'b0);
    send(32'hBF800000, 32'h40400000, 1'b1);
    drain();
  endtask

  task automatic test_equal_exp();
    send(32'h3F800000, 32'h3FC00000, 1'b0);
    send(32'h3FC00000, 32'h3F800000, 1'b1);
    send(32'h3F800000, 32'hBF800000, 1'b0);
    drain();
  endtask

  task automatic test_saturation();
    send(32'h4D800000, 32'h3F800000, 1'b0);
    send(32'h4C800000, 32'h3F800000, 1'b0);
    send(32'h4C000000, 32'h3F800000, 1'b0);
    send(32'h3F800000, 32'h7F000000, 1'b1);
    drain();
  endtask

  task automatic test_backpressure();
    logic [EW-1:0] snap;
    i_ready = 1'b0;
    fork
      begin
        send(32'h40000000, 32'h3F800000, 1'b0);
        send(32'h3F000000, 32'h41000000, 1'b1);
        send(32'hC1200000, 32'h40A00000, 1'b0);
        send(32'h42000000, 32'hC2800000, 1'b1);
        i_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        n_tests++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_full: o_valid=%b o_ready=%b expected 1/0", o_valid, o_ready);
        end
        snap = act_bundle;
        repeat (3) begin
          @(negedge clk);
          n_tests++;
          if (act_bundle !== snap || o_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_frozen: got %h o_ready=%b expected %h/0", act_bundle, o_ready, snap);
          end
        end
        @(posedge clk); #1; i_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_random_stream();
    bit done = 1'b0;
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          logic [DW-1:0] a;
          logic [DW-1:0] b;
          a = $urandom;
          b = $urandom;
          if (k % 2 == 0) b[30:23] = a[30:23] - 8'($urandom_range(0, 30));
          send(a, b, 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        i_valid = 1'b0;
        done = 1'b1;
      end
      begin
        for (int c = 0; c < 400 && !done; c++) begin
          @(posedge clk); #1;
          i_ready = 1'($urandom_range(0, 1));
        end
        i_ready = 1'b1;
      end
    join
    i_ready = 1'b1;
    drain();
  endtask

  task automatic test_reset_midop();
    i_ready = 1'b0;
    send(32'h40400000, 32'h3F800000, 1'b0);
    send(32'h3F800000, 32'h40400000, 1'b1);
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_full: o_valid=%b o_ready=%b expected 1/0", o_valid, o_ready);
    end
    @(posedge clk); #1;
    i_rst = 1'b1; i_valid = 1'b1; i_data_a = 32'h41000000; i_data_b = 32'h40000000;
    @(posedge clk); #1;
    exp_q.delete();
    i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0 || act_bundle !== '0 || o_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset: o_valid=%b bundle=%h o_ready=%b expected 0/0/1",
               o_valid, act_bundle, o_ready);
    end
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_capture: o_valid=%b expected 0", o_valid);
    end
    @(posedge clk); #1;
    send(32'h4D800000, 32'h3F800000, 1'b1);
    i_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_early: o_valid=%b expected 0", o_valid);
    end
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1 || o_exp_diff !== 8'd28 || o_shift_sat !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_latency: v=%b d=%0d sat=%b expected 1/28/1",
               o_valid, o_exp_diff, o_shift_sat);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_ordering();
    test_swap_sign();
    test_equal_exp();
    test_saturation();
    test_backpressure();
    test_random_stream();
    test_reset_midop();
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/add_sub_align_swap_pipe.md
Name: add_sub_align_swap_pipe

Overview:
Pipelined, parametrised operand-ordering stage for the FPU add/sub datapath.
- Accepts two packed IEEE-style operands plus an add/sub opcode under a valid/ready handshake.
- Orders the operands by magnitude and emits greater/less operands, the exponent difference, an alignment-saturation flag, the effective-subtract flag and the result sign.
- Sits between operand capture and the mantissa alignment shifter; generalises the combinational exponent swap to arbitrary formats, with backpressure and registered outputs.

Parameters:
- SIZE_EXP, 8, exponent field width.
- SIZE_MAN, 23, stored mantissa width (no hidden bit).
- SIZE_DATA (localparam, derived), 1+SIZE_EXP+SIZE_MAN; packing is {sign, exp, man}.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_valid  in  1  input operands valid.
- o_ready  out  1  stage can accept input this cycle.
- i_data_a  in  SIZE_DATA  operand A.
- i_data_b  in  SIZE_DATA  operand B.
- i_sub  in  1  1 = A-B, 0 = A+B.
- o_valid  out  1  output bundle valid.
- i_ready  in  1  downstream accepts output this cycle.
- o_greater_data  out  SIZE_DATA  larger-magnitude operand.
- o_less_data  out  SIZE_DATA  smaller-magnitude operand.
- o_exp_diff  out  SIZE_EXP  exp(greater) - exp(less), unsigned.
- o_shift_sat  out  1  o_exp_diff >= SIZE_MAN+3.
- o_swapped  out  1  B was ordered as greater.
- o_eff_sub  out  1  effective subtraction.
- o_sign_res  out  1  sign of result.

Behaviour:
- Two register stages, S1 and S2, each with its own valid bit.
- Latency is 2 cycles from accepted input (i_valid & o_ready) to o_valid with no backpressure.
- Throughput is 1 per cycle.
- S1 captures the operands, i_sub, the compare bit lt, and the raw exponent difference computed both ways.
- S2 captures the swapped data, the selected diff, sat, swapped, eff_sub and sign_res.
- lt is a strict less-than comparison; sign bits never take part.
  - Without the macro: lt = exp_a < exp_b.
  - Equal exponents give lt=0, so A is treated as greater.
- Swap rule:
  - lt=1: greater=B, less=A.
  - lt=0: greater=A, less=B.
- o_swapped = lt.
- o_exp_diff is always non-negative; it is computed at SIZE_EXP width with no wrap.
- o_shift_sat = (o_exp_diff >= SIZE_MAN+3).
- o_eff_sub = sign_a ^ sign_b ^ i_sub.
- o_sign_res:
  - lt=0: sign_a.
  - lt=1: sign_b ^ i_sub.
- Handshake:
  - S2 advances when !S2.valid | i_ready.
  - S1 advances when !S1.valid | S2 advances.
  - o_ready = !S1.valid | S2 advances (combinational from i_ready; no skid).
- While o_valid=1 and i_ready=0, every output holds stable and no transaction is dropped or duplicated.
- Order is preserved.
- Pipeline full (both valid) with i_ready=0: o_ready=0 and inputs are ignored.
- Accept and release in the same cycle are both allowed; occupancy stays constant.
- i_valid=0: stage bubbles propagate, and data registers may hold stale values (don't care while o_valid=0).
- Reset, including mid-operation: the next edge clears both valid bits and zeroes every output register.
  - After that edge: o_valid=0, all outputs 0, o_ready=1.
  - In-flight transactions are discarded.
- i_valid asserted during reset is not captured.

Optional Feature:
Macro ADD_SUB_SWAP_MANT_CMP_EN.
- Defined: lt = {exp_a,man_a} < {exp_b,man_b}, a full magnitude compare.
  - The less operand is then never larger in magnitude, so the downstream subtractor never produces a negative mantissa.
  - Equal magnitudes give lt=0.
- Undefined: exponent-only compare as described in Behaviour.
- Latency, ports and handshake are identical in both builds.

Test Plan:
1. Ordering: A=0x40400000 (3.0), B=0x3F800000 (1.0), i_sub=0, i_ready=1 → 2 cycles later o_greater=0x40400000, o_less=0x3F800000, o_exp_diff=1, o_swapped=0, o_eff_sub=0, o_sign_res=0, o_shift_sat=0.
2. Swap and sign: A=0x3F800000, B=0x40400000, i_sub=1 → o_greater=0x40400000, o_swapped=1, o_eff_sub=1, o_sign_res=1; then B=0xC0400000, i_sub=0 → o_eff_sub=1, o_sign_res=1.
3. Equal exponents: A=0x3F800000, B=0x3FC00000.
   - Without the macro: o_swapped=0, o_greater=A, o_exp_diff=0.
   - With ADD_SUB_SWAP_MANT_CMP_EN: o_swapped=1, o_greater=B.
4. Saturation: A=0x4D800000 (exp 155), B=0x3F800000 → o_exp_diff=28, o_shift_sat=1; A=0x4C800000 (exp 153) → diff=26, sat=1; A=0x4C000000 (exp 152) → diff=25, sat=0.
5. Backpressure: stream 4 back-to-back transactions with i_ready=0 for cycles 2–6.
   - o_ready falls once 2 entries are held.
   - Outputs stay frozen.
   - After i_ready=1, all 4 emerge in order with no loss or duplication.
6. Reset mid-op: both stages valid, assert i_rst for 1 cycle → next cycle o_valid=0, all outputs 0, o_ready=1; a fresh transaction after reset emerges 2 cycles after acceptance.
